// File: rtl/lp805x_cken_div_pkg.sv
// rtl/lp805x_cken_div_pkg.sv - shared constants, request states and sel-to-mask helpers
// Holds the counter width, select width, reset select value, the request
// FSM encoding and the clamp / mask functions shared with the timer block.
package lp805x_cken_div_pkg;

  localparam int TOP_PRESCALER = 7;
  localparam int SEL_W         = 3;
  localparam int MASK_EXT_W    = TOP_PRESCALER + 1;

  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(TOP_PRESCALER);
  localparam logic [SEL_W-1:0] RST_SEL = SEL_W'(7);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } req_state_t;

  // Indices above full speed are treated as full speed.
  function automatic logic [SEL_W-1:0] sel_clamp(input logic [SEL_W-1:0] sel);
    return (sel >= SEL_MAX) ? SEL_MAX : sel;
  endfunction

  // mask = 2^(TOP_PRESCALER - sel) - 1; built one bit wider so the
  // sel = 0 case (all ones) does not overflow before the subtract.
  function automatic logic [TOP_PRESCALER-1:0] sel_to_mask(input logic [SEL_W-1:0] sel);
    logic [SEL_W-1:0]      shamt;
    logic [MASK_EXT_W-1:0] span;
    logic [MASK_EXT_W-1:0] full;
    shamt = SEL_MAX - sel_clamp(sel);
    span  = MASK_EXT_W'(1) << shamt;
    full  = span - MASK_EXT_W'(1);
    return full[TOP_PRESCALER-1:0];
  endfunction

endpackage

// File: rtl/lp805x_cken_mask.sv
// rtl/lp805x_cken_mask.sv - combinational decoder from frequency index to counter mask
// Ports:
//   sel  - frequency index (clamped to full speed internally)
//   mask - low-order counter bits that must all be set for an enable
module lp805x_cken_mask
  import lp805x_cken_div_pkg::*;
(
  input  logic [SEL_W-1:0]         sel,
  output logic [TOP_PRESCALER-1:0] mask
);

  assign mask = sel_to_mask(sel);

endmodule

// File: rtl/lp805x_cken_div.sv
// rtl/lp805x_cken_div.sv - programmable clock-enable divider with boundary-aligned switching
// Ports:
//   clk, rst     - system clock, asynchronous active-high reset
//   sel_in       - requested frequency index from the scheduler
//   sel_load     - one-cycle strobe capturing sel_in as a request
//   hold         - suppresses clk_en without disturbing counting or switching
//   clk_en       - registered enable strobe, period 2^(TOP_PRESCALER - cur_sel)
//   cur_sel      - index currently in force
//   pending      - a request is captured and waiting for the boundary
//   switch_done  - one-cycle pulse when a new index takes effect
//   frame_tick   - one-cycle pulse per counter wrap
module lp805x_cken_div
  import lp805x_cken_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel_in,
  input  logic             sel_load,
  input  logic             hold,
  output logic             clk_en,
  output logic [SEL_W-1:0] cur_sel,
  output logic             pending,
  output logic             switch_done,
  output logic             frame_tick
);

  logic [TOP_PRESCALER-1:0] cnt;
  logic [TOP_PRESCALER-1:0] mask;
  logic                     boundary;
  logic [SEL_W-1:0]         sel_in_c;

  req_state_t       state_q;
  req_state_t       state_d;
  logic [SEL_W-1:0] pend_sel_q;
  logic [SEL_W-1:0] pend_sel_d;
  logic [SEL_W-1:0] cur_sel_d;
  logic             switch_d;

  // Switching only ever happens at the all-ones count: every mask is
  // satisfied there, so the old and new periods meet without a glitch.
  assign boundary = &cnt;
  assign sel_in_c = sel_clamp(sel_in);
  assign pending  = (state_q == ST_PENDING);

  lp805x_cken_mask u_mask (
    .sel  (cur_sel),
    .mask (mask)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      clk_en     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= cnt + TOP_PRESCALER'(1);
      clk_en     <= !hold && ((cnt & mask) == mask);
      frame_tick <= boundary;
    end
  end

  // Request FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_sel     <= RST_SEL;
      pend_sel_q  <= RST_SEL;
      switch_done <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_sel     <= cur_sel_d;
      pend_sel_q  <= pend_sel_d;
      switch_done <= switch_d;
    end
  end

  // Request FSM: next state. A load on the boundary bypasses PENDING.
  always_comb begin
    state_d = state_q;
    if (sel_load && boundary) begin
      state_d = ST_IDLE;
    end else if (sel_load) begin
      state_d = ST_PENDING;
    end else if ((state_q == ST_PENDING) && boundary) begin
      state_d = ST_IDLE;
    end
  end

  // Request FSM: outputs. A later load simply overwrites pend_sel.
  always_comb begin
    cur_sel_d  = cur_sel;
    pend_sel_d = pend_sel_q;
    switch_d   = 1'b0;
    if (sel_load && boundary) begin
      cur_sel_d = sel_in_c;
      switch_d  = 1'b1;
    end else if (sel_load) begin
      pend_sel_d = sel_in_c;
    end else if ((state_q == ST_PENDING) && boundary) begin
      cur_sel_d = pend_sel_q;
      switch_d  = 1'b1;
    end
  end

endmodule

// File: tb/tb_lp805x_cken_div.sv
// tb/tb_lp805x_cken_div.sv - self-checking bench for lp805x_cken_div
module tb_lp805x_cken_div;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sel_in;
  logic       sel_load;
  logic       hold;
  logic       clk_en;
  logic [2:0] cur_sel;
  logic       pending;
  logic       switch_done;
  logic       frame_tick;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  lp805x_cken_div dut (
    .clk         (clk),
    .rst         (rst),
    .sel_in      (sel_in),
    .sel_load    (sel_load),
    .hold        (hold),
    .clk_en      (clk_en),
    .cur_sel     (cur_sel),
    .pending     (pending),
    .switch_done (switch_done),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: cycle index within the 128-clock frame and the index
  // in force; enable when the frame position sits at the end of a period.
  int m_cnt;
  int m_cur;
  bit m_pend;
  int m_pv;
  bit e_en, e_sw, e_ft;

  function automatic int period_of(input int s);
    return 1 << (7 - s);
  endfunction

  function automatic int clamp7(input int s);
    return (s > 7) ? 7 : s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_cur  <= 7;
      m_pend <= 1'b0;
      m_pv   <= 7;
      e_en   <= 1'b0;
      e_sw   <= 1'b0;
      e_ft   <= 1'b0;
    end else begin
      e_en  <= !hold && ((m_cnt % period_of(m_cur)) == period_of(m_cur) - 1);
      e_ft  <= (m_cnt == 127);
      m_cnt <= (m_cnt + 1) % 128;
      if (sel_load && m_cnt == 127) begin
        m_cur  <= clamp7(int'(sel_in));
        m_pend <= 1'b0;
        e_sw   <= 1'b1;
      end else if (sel_load) begin
        m_pend <= 1'b1;
        m_pv   <= clamp7(int'(sel_in));
        e_sw   <= 1'b0;
      end else if (m_pend && m_cnt == 127) begin
        m_cur  <= m_pv;
        m_pend <= 1'b0;
        e_sw   <= 1'b1;
      end else begin
        e_sw <= 1'b0;
      end
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      logic [6:0] act, exp;
      act = {clk_en, cur_sel, pending, switch_done, frame_tick};
      exp = {e_en, 3'(m_cur), m_pend, e_sw, e_ft};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL outputs t=%0t cnt=%0d {en,sel,pend,sw,ft} got %b want %b",
                 $time, m_cnt, act, exp);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
    end
  endtask

  task automatic wait_cnt(input int v);
    int k = 0;
    while (m_cnt != v && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (m_cnt != v) chk("wait_cnt_timeout", m_cnt, v);
  endtask

  task automatic load_at(input int v, input int s);
    wait_cnt(v);
    sel_in   = 3'(s);
    sel_load = 1'b1;
    @(negedge clk);
    sel_load = 1'b0;
  endtask

  initial begin
    int sw_cnt;
    rst      = 1'b0;
    sel_in   = 3'd0;
    sel_load = 1'b0;
    hold     = 1'b0;
    #1 rst = 1'b1;
    #1 chk_on = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_clk_en", int'(clk_en), 0);
    chk("rst_cur_sel", int'(cur_sel), 7);
    chk("rst_pending", int'(pending), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_clk_en", int'(clk_en), 1);
    repeat (140) @(negedge clk);

    // Deferred switch to 4.
    load_at(10, 4);
    chk("sel4_pending", int'(pending), 1);
    wait_cnt(0);
    chk("sel4_switch_done", int'(switch_done), 1);
    chk("sel4_cur_sel", int'(cur_sel), 4);
    chk("sel4_pending_low", int'(pending), 0);
    wait_cnt(7);
    chk("sel4_en_cnt7", int'(clk_en), 0);
    @(negedge clk);
    chk("sel4_en_cnt8", int'(clk_en), 1);

    // Last request wins, single switch_done.
    load_at(20, 5);
    load_at(40, 2);
    sw_cnt = 0;
    repeat (120) begin
      @(negedge clk);
      if (switch_done) sw_cnt++;
    end
    chk("lastwins_sw_count", sw_cnt, 1);
    chk("lastwins_cur_sel", int'(cur_sel), 2);

    // Load exactly on the boundary.
    load_at(127, 0);
    chk("bnd_pending", int'(pending), 0);
    chk("bnd_switch_done", int'(switch_done), 1);
    chk("bnd_cur_sel", int'(cur_sel), 0);
    repeat (260) @(negedge clk);

    // hold across a switch from 7 to 6.
    load_at(127, 7);
    load_at(100, 6);
    wait_cnt(115);
    hold = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("hold_clk_en", int'(clk_en), 0);
      if (m_cnt == 0) chk("hold_switch_done", int'(switch_done), 1);
    end
    hold = 1'b0;
    repeat (10) @(negedge clk);
    chk("hold_cur_sel", int'(cur_sel), 6);

    // Asynchronous reset drops a pending request.
    load_at(50, 3);
    chk("arst_pending_pre", int'(pending), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_pending", int'(pending), 0);
    chk("arst_clk_en", int'(clk_en), 0);
    chk("arst_switch_done", int'(switch_done), 0);
    chk("arst_cur_sel", int'(cur_sel), 7);
    @(negedge clk);
    rst = 1'b0;
    sw_cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (switch_done) sw_cnt++;
    end
    chk("arst_no_switch", sw_cnt, 0);
    chk("arst_cur_sel_after", int'(cur_sel), 7);

    // Randomized traffic, including loads forced onto the boundary.
    repeat (2000) begin
      hold     = ($urandom_range(0, 7) == 0);
      sel_in   = 3'($urandom_range(0, 7));
      sel_load = ($urandom_range(0, 15) == 0) ||
                 ((m_cnt == 127) && ($urandom_range(0, 1) == 1));
      @(negedge clk);
    end
    sel_load = 1'b0;
    hold     = 1'b0;
    repeat (3) @(negedge clk);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
